pixel_row_packer: RTL

Upstream stage of the median filter: converts a serial 8-bit pixel stream into complete image rows. Each row is presented as one wide unpacked array, `row_out`, that the median filter consumes as its row input. A two-entry row buffer (ping-pong) lets the next row fill while the previous one waits to be taken. The block also tracks row and frame position and flags malformed start-of-frame markers.

---
 rtl/pixel_row_packer.sv | 92 +++++++++
 1 files changed

// File: rtl/pixel_row_packer.sv
// Serial pixel stream to full-row packer with a two-slot ping-pong row buffer.
// Tracks column/row position and flags SOF markers that arrive mid-row.
module pixel_row_packer #(
    parameter int SIZE = 100,
    parameter int DW   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DW-1:0]           pix_in,
    input  logic                    pix_valid,
    input  logic                    pix_sof,
    output logic                    pix_ready,
    output logic [DW-1:0]           row_out [SIZE-1:0],
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic [$clog2(SIZE)-1:0] row_idx,
    output logic                    row_last,
    output logic                    sof_err
);
    localparam int RW = $clog2(SIZE);
    localparam logic [RW-1:0] LAST = RW'(SIZE - 1);

    logic [DW-1:0] slot [2][SIZE];
    logic [RW-1:0] tag [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [RW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          pop;
    logic          complete;

    assign pix_ready = (count != 2'd2);
    assign row_valid = (count != 2'd0);
    assign accept    = pix_valid & pix_ready;
    assign pop       = row_valid & row_ready;
    assign complete  = accept & ~pix_sof & (col == LAST);
    assign row_idx   = tag[rd_ptr];
    assign row_last  = (row_idx == LAST);

    always_comb begin
        for (int c = 0; c < SIZE; c++) begin
            row_out[c] = slot[rd_ptr][c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                tag[s] <= '0;
                for (int c = 0; c < SIZE; c++) begin
                    slot[s][c] <= '0;
                end
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            col     <= '0;
            row     <= '0;
            sof_err <= 1'b0;
        end else begin
            sof_err <= accept & pix_sof & (col != '0);
            if (accept) begin
                if (pix_sof) begin
                    // partial row (if any) is overwritten in place
                    slot[wr_ptr][0] <= pix_in;
                    col             <= RW'(1);
                    row             <= '0;
                end else begin
                    slot[wr_ptr][col] <= pix_in;
                    if (col == LAST) begin
                        tag[wr_ptr] <= row;
                        wr_ptr      <= ~wr_ptr;
                        col         <= '0;
                        row         <= (row == LAST) ? '0 : row + RW'(1);
                    end else begin
                        col <= col + RW'(1);
                    end
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({complete, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule
